// File: rtl/button_pkg.sv
// Shared types and constants for the push-button reader.
package button_pkg;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;
  localparam int EVT_CODE_W = 4;
endpackage

// File: rtl/button_reader_if.sv
// Button pins in, debounced levels/pulses and the encoded event out.
interface button_reader_if #(parameter int N_BTN = 4);
  import button_pkg::*;

  // `release` is a reserved word, so the release pulse vector is `rel`.
  logic [N_BTN-1:0]      btn_n;
  logic [N_BTN-1:0]      level;
  logic [N_BTN-1:0]      press;
  logic [N_BTN-1:0]      rel;
  logic [N_BTN-1:0]      rpt;
  logic                  evt_valid;
  logic [EVT_CODE_W-1:0] evt_code;

  modport master (input btn_n, output level, press, rel, rpt, evt_valid, evt_code);
  modport slave  (output btn_n, input level, press, rel, rpt, evt_valid, evt_code);
endinterface

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser, stable-time debounce, edge pulses and
// the auto-repeat FSM.
module btn_debounce
  import button_pkg::*;
#(
  parameter int DB_CYCLES    = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ?
                          ((REPEAT_DELAY > 2) ? REPEAT_DELAY : 2) :
                          ((REPEAT_RATE  > 2) ? REPEAT_RATE  : 2);
  localparam int DB_W = $clog2(DB_CYCLES);
  localparam int RP_W = $clog2(RP_MAX);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RR_LAST = RP_W'(REPEAT_RATE - 1);

  logic            s1, s2, in;
  logic [DB_W-1:0] db_cnt;
  logic            accept;

  rpt_state_t      state, state_nx;
  logic [RP_W-1:0] rp_cnt, rp_cnt_nx;
  logic            rpt_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= btn_n;
      s2 <= s1;
    end
  end

  assign in     = ~s2;
  assign accept = (in != level) && (db_cnt == DB_LAST);

  // The counter only runs while input and level disagree; accept fires at its
  // terminal value, so it never climbs past DB_LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      press <= accept & in;
      rel   <= accept & ~in;
      if (in == level) begin
        db_cnt <= '0;
      end else if (accept) begin
        level  <= in;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rp_cnt <= '0;
      rpt    <= 1'b0;
    end else begin
      state  <= state_nx;
      rp_cnt <= rp_cnt_nx;
      rpt    <= rpt_nx;
    end
  end

  // A falling level wins over a due repeat, so release never carries a rpt.
  always_comb begin
    state_nx  = state;
    rp_cnt_nx = rp_cnt;
    rpt_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (accept && in && (REPEAT_DELAY != 0)) begin
          state_nx  = DELAY;
          rp_cnt_nx = '0;
        end
      end
      DELAY: begin
        if (accept && !in) begin
          state_nx  = IDLE;
          rp_cnt_nx = '0;
        end else if (rp_cnt == RD_LAST) begin
          state_nx  = REPEAT;
          rp_cnt_nx = '0;
          rpt_nx    = 1'b1;
        end else begin
          rp_cnt_nx = rp_cnt + RP_W'(1);
        end
      end
      REPEAT: begin
        if (accept && !in) begin
          state_nx  = IDLE;
          rp_cnt_nx = '0;
        end else if (rp_cnt == RR_LAST) begin
          rp_cnt_nx = '0;
          rpt_nx    = 1'b1;
        end else begin
          rp_cnt_nx = rp_cnt + RP_W'(1);
        end
      end
      default: begin
        state_nx  = IDLE;
        rp_cnt_nx = '0;
      end
    endcase
  end
endmodule

// File: rtl/button_reader.sv
// N debounced push-buttons with press/release/repeat pulses and a registered
// lowest-index event encoder.
module button_reader
  import button_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int DB_CYCLES    = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic clk,
  input  logic reset,
  button_reader_if.master bus
);
  logic [N_BTN-1:0]      level, press, rel, rpt, hit;
  logic [EVT_CODE_W-1:0] code_nx, evt_code;
  logic                  evt_valid;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES   (DB_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_btn (
      .clk  (clk),
      .reset(reset),
      .btn_n(bus.btn_n[i]),
      .level(level[i]),
      .press(press[i]),
      .rel  (rel[i]),
      .rpt  (rpt[i])
    );
  end

  assign hit = press | rpt;

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    code_nx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (hit[i]) code_nx = EVT_CODE_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      evt_valid <= 1'b0;
      evt_code  <= '0;
    end else begin
      evt_valid <= |hit;
      evt_code  <= code_nx;
    end
  end

  assign bus.level     = level;
  assign bus.press     = press;
  assign bus.rel       = rel;
  assign bus.rpt       = rpt;
  assign bus.evt_valid = evt_valid;
  assign bus.evt_code  = evt_code;
endmodule

// File: tb/tb_button_reader.sv
// Directed scenarios plus random bouncy inputs, checked every cycle against a
// window/arithmetic reference model.
module tb_button_reader;
  import button_pkg::*;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;

  button_reader_if #(.N_BTN(N)) bus ();

  button_reader #(
    .N_BTN       (N),
    .DB_CYCLES   (DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [N-1:0] e_lvl, e_press, e_rel, e_rpt;
  logic         e_ev;
  logic [3:0]   e_code;
  bit           dly1 [N];
  bit           dly2 [N];
  bit           win  [N][$];
  int           tpress [N];

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cyc, got, exp);
  endtask

  // Level flips once the synchronised input has shown the opposite value for
  // DB straight cycles; repeats fall on press+RD+k*RR while still held.
  task automatic model_step();
    logic [N-1:0] hit;
    bit           found, all_opp;
    int           d;
    if (reset) begin
      e_lvl = '0; e_press = '0; e_rel = '0; e_rpt = '0;
      e_ev = 1'b0; e_code = '0;
      for (int i = 0; i < N; i++) begin
        dly1[i] = 1'b0; dly2[i] = 1'b0; win[i].delete(); tpress[i] = 0;
      end
    end else begin
      hit = e_press | e_rpt;
      e_ev = |hit;
      e_code = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (hit[i] && !found) begin
          e_code = 4'(i);
          found = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) begin
        e_press[i] = 1'b0; e_rel[i] = 1'b0; e_rpt[i] = 1'b0;
        win[i].push_back(dly2[i]);
        if (win[i].size() > DB) void'(win[i].pop_front());
        all_opp = (win[i].size() == DB);
        foreach (win[i][k]) if (win[i][k] == e_lvl[i]) all_opp = 1'b0;
        if (all_opp) begin
          e_lvl[i] = ~e_lvl[i];
          win[i].delete();
          if (e_lvl[i]) begin
            e_press[i] = 1'b1;
            tpress[i] = cyc;
          end else begin
            e_rel[i] = 1'b1;
          end
        end else if (e_lvl[i] && RD > 0) begin
          d = cyc - tpress[i];
          if (d >= RD && ((d - RD) % RR) == 0) e_rpt[i] = 1'b1;
        end
        dly2[i] = dly1[i];
        dly1[i] = ~bus.btn_n[i];
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("level",     int'(bus.level),     int'(e_lvl));
    chk("press",     int'(bus.press),     int'(e_press));
    chk("release",   int'(bus.rel),       int'(e_rel));
    chk("rpt",       int'(bus.rpt),       int'(e_rpt));
    chk("evt_valid", int'(bus.evt_valid), int'(e_ev));
    chk("evt_code",  int'(bus.evt_code),  int'(e_code));
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.btn_n = '1;
    run(3);
    reset = 1'b0;
    run(3);

    // clean press on button 2
    bus.btn_n[2] = 1'b0; run(20);
    bus.btn_n[2] = 1'b1; run(12);

    // bounce on button 0
    bus.btn_n[0] = 1'b0; run(3);
    bus.btn_n[0] = 1'b1; run(1);
    bus.btn_n[0] = 1'b0; run(12);
    bus.btn_n[0] = 1'b1; run(12);

    // long hold on button 1 for repeats
    bus.btn_n[1] = 1'b0; run(40);
    bus.btn_n[1] = 1'b1; run(15);

    // simultaneous press of buttons 1 and 3
    bus.btn_n[1] = 1'b0; bus.btn_n[3] = 1'b0; run(8);
    bus.btn_n = '1; run(10);

    // reset while repeating, button still held
    bus.btn_n[0] = 1'b0; run(22);
    reset = 1'b1; run(2);
    reset = 1'b0; run(25);
    bus.btn_n[0] = 1'b1; run(10);

    // short glitch on button 3
    bus.btn_n[3] = 1'b0; run(3);
    bus.btn_n[3] = 1'b1; run(10);

    // random bouncy stimulus with occasional reset
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) bus.btn_n[i] = ~bus.btn_n[i];
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    bus.btn_n = '1;
    run(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
